udp_tx_pkt_sched: RTL

Packet scheduler between the Flash-data async FIFO read side and the UDP transmit engine, all in the gmii_tx_clk domain. It waits for one full packet of words in the FIFO and issues a single-cycle start with the byte count. It then gates the UDP engine's word requests onto the FIFO read enable and counts words. It waits for the engine's done, enforces an inter-packet gap, and reports packet count and error status.

---
 rtl/udp_tx_pkg.sv | 25 ++
 rtl/udp_tx_pkt_sched.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/udp_tx_pkg.sv
// Shared definitions for the UDP transmit packet scheduler.
//   - state encodings (3-bit) and the FSM state type
//   - bytes-per-word constant and default packet size in words
//   - width of the shared timeout/gap counter
package udp_tx_pkg;

  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_START     = 3'd1;
  localparam logic [2:0] ENC_SEND      = 3'd2;
  localparam logic [2:0] ENC_WAIT_DONE = 3'd3;
  localparam logic [2:0] ENC_GAP       = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ENC_IDLE,
    START     = ENC_START,
    SEND      = ENC_SEND,
    WAIT_DONE = ENC_WAIT_DONE,
    GAP       = ENC_GAP
  } state_t;

  localparam int unsigned BYTES_PER_WORD    = 4;
  localparam int unsigned DEF_WORDS_PER_PKT = 256;
  localparam int unsigned TMR_W             = 13;

endpackage

// File: rtl/udp_tx_pkt_sched.sv
// Packet scheduler between the Flash-data FIFO read side and the UDP TX engine
// (single gmii_tx_clk domain). Waits for a full packet in the FIFO, pulses
// tx_start_en, forwards engine word requests to the FIFO read enable, waits
// for the engine's done, then enforces an inter-packet gap.
// Ports:
//   gmii_tx_clk, I_rst       clock, async active-high reset
//   sched_en, err_clr        scheduling enable (level), sticky-error clear (pulse)
//   rd_data_count,
//   fifo_empty, fifo_dout    FIFO read-side status and data
//   fifo_rd_en               FIFO read enable (combinational)
//   udp_tx_req, udp_tx_done  engine word request / packet-complete pulse
//   tx_start_en, tx_byte_num start pulse and packet byte count to the engine
//   tx_data                  fifo_dout passthrough
//   busy, pkt_cnt            activity flag, completed packet counter (wraps)
//   underflow_err,
//   timeout_err              sticky error flags
module udp_tx_pkt_sched
  import udp_tx_pkg::*;
#(
  parameter int unsigned WORDS_PER_PKT = DEF_WORDS_PER_PKT,
  parameter int unsigned CNT_W         = 9,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned GAP_CYCLES    = 12,
  parameter int unsigned DONE_TMO      = 4096
) (
  input  logic              gmii_tx_clk,
  input  logic              I_rst,
  input  logic              sched_en,
  input  logic              err_clr,
  input  logic [CNT_W-1:0]  rd_data_count,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              udp_tx_req,
  input  logic              udp_tx_done,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic [15:0]       pkt_cnt,
  output logic              underflow_err,
  output logic              timeout_err
);

  localparam int unsigned WC_W = $clog2(WORDS_PER_PKT + 1);

  state_t            state, state_nxt;
  logic [WC_W-1:0]   word_cnt, word_cnt_nxt;
  logic [TMR_W-1:0]  tmr, tmr_nxt;
  logic [15:0]       pkt_cnt_nxt;
  logic              start_nxt;
  logic              underflow_nxt, timeout_nxt;
  logic              threshold_met;
  logic              rd_en;

  assign tx_data       = fifo_dout;
  assign fifo_rd_en    = rd_en;
  assign threshold_met = rd_data_count >= CNT_W'(WORDS_PER_PKT);

  // Read gating: only in SEND, only on a request the FIFO can serve.
  always_comb begin
    rd_en = 1'b0;
    if (state == SEND) begin
      rd_en = udp_tx_req && !fifo_empty && (word_cnt < WC_W'(WORDS_PER_PKT));
    end
  end

  // State and counter registers.
  always_ff @(posedge gmii_tx_clk or posedge I_rst) begin
    if (I_rst) begin
      state         <= IDLE;
      word_cnt      <= '0;
      tmr           <= '0;
      pkt_cnt       <= '0;
      tx_start_en   <= 1'b0;
      busy          <= 1'b0;
      underflow_err <= 1'b0;
      timeout_err   <= 1'b0;
      tx_byte_num   <= 16'(WORDS_PER_PKT * BYTES_PER_WORD);
    end else begin
      state         <= state_nxt;
      word_cnt      <= word_cnt_nxt;
      tmr           <= tmr_nxt;
      pkt_cnt       <= pkt_cnt_nxt;
      tx_start_en   <= start_nxt;
      busy          <= (state_nxt != IDLE);
      underflow_err <= underflow_nxt;
      timeout_err   <= timeout_nxt;
      tx_byte_num   <= 16'(WORDS_PER_PKT * BYTES_PER_WORD);
    end
  end

  // Next-state, counters and sticky errors. Clear is applied first so a
  // same-cycle error set overrides it.
  always_comb begin
    state_nxt     = state;
    word_cnt_nxt  = word_cnt;
    tmr_nxt       = tmr;
    pkt_cnt_nxt   = pkt_cnt;
    start_nxt     = 1'b0;
    underflow_nxt = underflow_err;
    timeout_nxt   = timeout_err;

    if (err_clr) begin
      underflow_nxt = 1'b0;
      timeout_nxt   = 1'b0;
    end

    case (state)
      IDLE: begin
        if (sched_en && threshold_met) begin
          state_nxt = START;
          start_nxt = 1'b1;
        end
      end

      START: begin
        word_cnt_nxt = '0;
        state_nxt    = SEND;
      end

      SEND: begin
        if (rd_en) begin
          word_cnt_nxt = word_cnt + WC_W'(1);
          // Leave on the edge that takes the last word.
          if (word_cnt == WC_W'(WORDS_PER_PKT - 1)) begin
            state_nxt = WAIT_DONE;
            tmr_nxt   = '0;
          end
        end
        if (udp_tx_req && fifo_empty) begin
          underflow_nxt = 1'b1;
        end
      end

      WAIT_DONE: begin
        if (udp_tx_done) begin
          pkt_cnt_nxt = pkt_cnt + 16'd1;
          state_nxt   = GAP;
          tmr_nxt     = '0;
        end else if (tmr == TMR_W'(DONE_TMO - 1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = GAP;
          tmr_nxt     = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end

      GAP: begin
        if (tmr == TMR_W'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
